cus19_dmem_burst: RTL and testbench
===================================

# cus19_dmem_burst

Parametrised single-port data memory with an internal burst controller, used as the MEM-stage data store of the Custom-19 core and as the block-transfer buffer for the cryptographic accelerator. It clears itself by sequential sweep after reset. It accepts one read or write burst of 1..2^BLEN_W beats per request over a ready/valid handshake. Reads are synchronous and registered, replacing the earlier combinational tri-stated read path.

## Interface
- ADDR_W, 11, word address width; depth = 2^ADDR_W words
- DATA_W, 8, word width
- BLEN_W, 4, burst-length field width; a burst is blen_in+1 beats (max 16)

- clk_in  in  1  clock, rising edge
- rst_in  in  1  reset, asynchronous, active-low
- req_in  in  1  request strobe; accepted when req_in & ready_out
- we_in  in  1  1 = write burst, 0 = read burst; sampled at accept
- addr_in  in  ADDR_W  burst start address; sampled at accept
- blen_in  in  BLEN_W  beats minus one; sampled at accept
- wvalid_in  in  1  write beat valid
- wdata_in  in  DATA_W  write beat data
- ready_out  out  1  controller idle; accepting requests
- rvalid_out  out  1  rdata_out carries a read beat this cycle
- rdata_out  out  DATA_W  read data; holds the last value when rvalid_out=0
- done_out  out  1  one-cycle pulse when the burst completes
- wrap_out  out  1  valid with done_out; 1 if the burst crossed address 2^ADDR_W-1 → 0

## Operation
- States: CLEAR, IDLE, RD, WR.
- **Reset** (async): state=CLEAR, clear counter=0. All outputs are 0, including rdata_out.
- **CLEAR**:
  - Writes 0 to mem[counter] each cycle; counter increments.
  - After the write of address 2^ADDR_W-1 → IDLE.
  - ready_out=0 throughout.
  - No done_out pulse.
- **IDLE**:
  - ready_out=1.
  - On accept, latch addr, blen and we; beat counter=0; go to RD or WR.
  - req_in while ready_out=0 is ignored and not queued.
- **RD**:
  - One beat per cycle with no stall: each edge reads mem[addr+i] into rdata_out and asserts rvalid_out.
  - The edge that captures the last beat also sets done_out and wrap_out, and state → IDLE.
- **WR**:
  - On each edge with wvalid_in=1, write wdata_in to mem[addr+i] and increment i.
  - wvalid_in=0 stalls the burst with no write and no timeout.
  - The edge that writes the last beat sets done_out and wrap_out, and state → IDLE.
  - wvalid_in outside WR is ignored.
- **Addressing**: addr+i is computed modulo 2^ADDR_W (ADDR_W-bit add, carry dropped). The carry-out seen on any beat sets the internal wrap flag, which is cleared at accept.
- **Reset mid-burst**: the burst is aborted immediately, rvalid_out/done_out drop, and the block re-enters CLEAR. A partially written burst is wiped by the sweep.

## Timing
- ready_out returns high in the first cycle after CLEAR finishes. CLEAR takes 2^ADDR_W cycles after rst_in deasserts.
- Read latency is 2 cycles: accept edge N, first rvalid_out in cycle N+2. Beats are on consecutive cycles.
- done_out is coincident with the last rvalid_out.
- Write: done_out is high in the cycle after the edge that writes the last beat.
- done_out cycle = IDLE cycle: ready_out=1 concurrently, so back-to-back requests are accepted with zero dead cycles.
- rdata_out, rvalid_out, done_out and wrap_out are all registered outputs.

## Structure
- Shared package cus19_pkg holds:
  - the state typedef (CLEAR/IDLE/RD/WR)
  - default localparams for ADDR_W/DATA_W/BLEN_W, shared with the crypto DMA
- One sub-module, cus19_sram_1rw: a plain array with synchronous write, synchronous registered read, no reset on the array, one port. The controller muxes clear, read and write addresses onto it.

## Test plan
- **Reset sweep**: deassert rst_in with ADDR_W=4 → ready_out=0 for 16 cycles, then 1. Read 16 beats at addr 0 → all rdata_out=0x00.
- **Write/read burst**: write blen=3 at 0x010 with data A1,B2,C3,D4, no stalls → done_out one cycle after the 4th write edge. Read back → A1,B2,C3,D4 on 4 consecutive cycles starting accept+2; done_out coincides with D4.
- **Stalled write**: wvalid_in toggles 1,0,0,1 over blen=1 → exactly 2 writes, done_out after the 2nd valid edge, and memory is unchanged where wvalid_in=0.
- **Wrap**: write blen=2 at 0x7FF (ADDR_W=11) → locations 0x7FF, 0x000, 0x001 written, and wrap_out=1 with done_out. A non-wrapping burst → wrap_out=0.
- **Back-to-back and ignore**: assert req_in during RD → ignored. A new request in the done_out cycle is accepted with no bubble.
- **Reset mid-burst**: assert rst_in during the 2nd beat of a write burst → outputs drop to 0 asynchronously, CLEAR reruns, and the target locations read 0x00 afterwards.

Source files
------------

// File: rtl/cus19_pkg.sv
// Shared Custom-19 memory types: controller state encoding and default widths,
// also used by the crypto DMA so both agree on word/burst geometry.
package cus19_pkg;
    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 8;
    localparam int BLEN_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RD    = 2'd2,
        ST_WR    = 2'd3
    } state_t;
endpackage

// File: rtl/cus19_dmem_burst_if.sv
// Request/write-beat/read-beat bundle of the burst data memory.
// master drives requests and write beats; slave returns ready, read beats and completion.
interface cus19_dmem_burst_if
    import cus19_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BLEN_W = BLEN_W_DEF
);
    logic              req_in;
    logic              we_in;
    logic [ADDR_W-1:0] addr_in;
    logic [BLEN_W-1:0] blen_in;
    logic              wvalid_in;
    logic [DATA_W-1:0] wdata_in;
    logic              ready_out;
    logic              rvalid_out;
    logic [DATA_W-1:0] rdata_out;
    logic              done_out;
    logic              wrap_out;

    modport master (
        output req_in, we_in, addr_in, blen_in, wvalid_in, wdata_in,
        input  ready_out, rvalid_out, rdata_out, done_out, wrap_out
    );

    modport slave (
        input  req_in, we_in, addr_in, blen_in, wvalid_in, wdata_in,
        output ready_out, rvalid_out, rdata_out, done_out, wrap_out
    );
endinterface

// File: rtl/cus19_sram_1rw.sv
// Single-port word array: synchronous write, registered read, no array reset.
// One access per cycle; read data appears the cycle after re.
module cus19_sram_1rw #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk_in,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk_in) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/cus19_dmem_burst.sv
// Burst controller over a 1RW SRAM: self-clears after reset, then serves 1..2^BLEN_W beat bursts.
// Read beats 2 cycles after accept, unstallable; write beats stall on wvalid_in=0; ready only in IDLE.
module cus19_dmem_burst
    import cus19_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BLEN_W = BLEN_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    cus19_dmem_burst_if.slave bus
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_q, base_q;
    logic [BLEN_W-1:0] blen_q, beat_q;
    logic              drain_q, rd_pend_q, rd_last_q, wrap_q;
    logic              rvalid_q, done_q, wrap_out_q;
    logic [DATA_W-1:0] rdata_q;

    logic              accept, rd_issue, wr_beat, last_beat, wrap_now, clearing;
    logic [ADDR_W:0]   sum;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata, sram_rdata;

    always_comb begin
        clearing  = (state_q == ST_CLEAR);
        accept    = (state_q == ST_IDLE) && bus.req_in;
        rd_issue  = (state_q == ST_RD) && !drain_q;
        wr_beat   = (state_q == ST_WR) && bus.wvalid_in;
        last_beat = (beat_q == blen_q);
        // Carry out of base+beat is the wrap indication for this beat
        sum       = {1'b0, base_q} + {{(ADDR_W + 1 - BLEN_W){1'b0}}, beat_q};
        wrap_now  = wrap_q | ((rd_issue | wr_beat) & sum[ADDR_W]);
        sram_we   = clearing | wr_beat;
        sram_addr = clearing ? clr_q : sum[ADDR_W-1:0];
        sram_wdata = clearing ? '0 : bus.wdata_in;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (&clr_q) state_d = ST_IDLE;
            ST_IDLE:  if (bus.req_in) state_d = bus.we_in ? ST_WR : ST_RD;
            ST_RD:    if (rd_pend_q && rd_last_q) state_d = ST_IDLE;
            ST_WR:    if (wr_beat && last_beat) state_d = ST_IDLE;
            default:  state_d = ST_CLEAR;
        endcase
    end

    cus19_sram_1rw #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_sram (
        .clk_in (clk_in),
        .we     (sram_we),
        .re     (rd_issue),
        .addr   (sram_addr),
        .wdata  (sram_wdata),
        .rdata  (sram_rdata)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_CLEAR;
            clr_q      <= '0;
            base_q     <= '0;
            blen_q     <= '0;
            beat_q     <= '0;
            drain_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_last_q  <= 1'b0;
            wrap_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            done_q     <= 1'b0;
            wrap_out_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rvalid_q   <= 1'b0;
            done_q     <= 1'b0;
            wrap_out_q <= 1'b0;
            rd_pend_q  <= rd_issue;
            rd_last_q  <= rd_issue & last_beat;
            if (clearing) clr_q <= clr_q + ADDR_W'(1);
            if (accept) begin
                base_q  <= bus.addr_in;
                blen_q  <= bus.blen_in;
                beat_q  <= '0;
                drain_q <= 1'b0;
                wrap_q  <= 1'b0;
            end else if (rd_issue || wr_beat) begin
                wrap_q <= wrap_now;
                if (!last_beat) beat_q <= beat_q + BLEN_W'(1);
                else if (rd_issue) drain_q <= 1'b1;
            end
            // Second read stage: SRAM output lands in rdata one edge after issue
            if (rd_pend_q) begin
                rvalid_q <= 1'b1;
                rdata_q  <= sram_rdata;
                if (rd_last_q) begin
                    done_q     <= 1'b1;
                    wrap_out_q <= wrap_q;
                end
            end
            if (wr_beat && last_beat) begin
                done_q     <= 1'b1;
                wrap_out_q <= wrap_now;
            end
        end
    end

    assign bus.ready_out  = (state_q == ST_IDLE);
    assign bus.rvalid_out = rvalid_q;
    assign bus.rdata_out  = rdata_q;
    assign bus.done_out   = done_q;
    assign bus.wrap_out   = wrap_out_q;
endmodule

// File: tb/tb_cus19_dmem_burst.sv
// Randomized bench for cus19_dmem_burst against a flat-array memory model.
// Timing expectations are derived from the documented beat/latency rules.
module tb_cus19_dmem_burst;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int BW = 4;
    localparam int DEPTH = 1 << AW;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    cus19_dmem_burst_if #(.ADDR_W(AW), .DATA_W(DW), .BLEN_W(BW)) bus ();

    cus19_dmem_burst #(.ADDR_W(AW), .DATA_W(DW), .BLEN_W(BW)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] wr_dat [16];

    logic [DW-1:0] rd_data [$];
    logic [63:0]   rd_vmask;
    int            rd_done_k, rd_wait;
    logic          rd_wrap;

    int            wr_j, wr_early, wr_wait;
    logic          wr_done_last, wr_wrap;

    function automatic logic [63:0] exp_vmask(input int bl);
        return ((64'd1 << (bl + 1)) - 64'd1) << 2;
    endfunction

    function automatic logic exp_wrap(input int a, input int bl);
        return (a + bl) >= DEPTH;
    endfunction

    task automatic model_write(input int a, input int bl);
        for (int i = 0; i <= bl; i++) mem_m[(a + i) % DEPTH] = wr_dat[i];
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    task automatic count_clear(output int n);
        n = 0;
        while (bus.ready_out !== 1'b1 && n < 3000) begin
            @(posedge clk_in); #1;
            n++;
        end
    endtask

    task automatic run_read(input int a, input int bl, input bit poke);
        int k;
        rd_data.delete();
        rd_wait = 0; rd_done_k = -1; rd_vmask = '0; rd_wrap = 1'b0;
        while (bus.ready_out !== 1'b1 && rd_wait < 100) begin
            @(posedge clk_in); #1;
            rd_wait++;
        end
        bus.req_in = 1'b1; bus.we_in = 1'b0;
        bus.addr_in = AW'(a); bus.blen_in = BW'(bl);
        @(posedge clk_in); #1;
        bus.req_in = poke; bus.we_in = 1'b1;
        bus.addr_in = AW'($urandom); bus.blen_in = BW'($urandom);
        k = 0;
        while (rd_done_k < 0 && k < 40) begin
            @(posedge clk_in); #1;
            k++;
            if (bus.rvalid_out === 1'b1) begin
                rd_data.push_back(bus.rdata_out);
                rd_vmask[k] = 1'b1;
            end
            if (bus.done_out === 1'b1) begin
                rd_done_k = k;
                rd_wrap = bus.wrap_out;
                bus.req_in = 1'b0;
            end
        end
        bus.req_in = 1'b0;
    endtask

    task automatic run_write(input int a, input int bl, input logic [63:0] pat);
        int beats;
        logic v;
        wr_wait = 0; wr_j = -1; wr_early = 0; wr_done_last = 1'b0; wr_wrap = 1'b0;
        while (bus.ready_out !== 1'b1 && wr_wait < 100) begin
            @(posedge clk_in); #1;
            wr_wait++;
        end
        bus.req_in = 1'b1; bus.we_in = 1'b1;
        bus.addr_in = AW'(a); bus.blen_in = BW'(bl);
        // A beat offered while still IDLE must not be written
        bus.wvalid_in = 1'b1; bus.wdata_in = DW'($urandom);
        @(posedge clk_in); #1;
        bus.req_in = 1'b0;
        beats = 0;
        for (int j = 0; j < 200 && beats <= bl; j++) begin
            v = (j < 64) ? pat[j] : 1'b1;
            bus.wvalid_in = v;
            bus.wdata_in = v ? wr_dat[beats] : DW'($urandom);
            @(posedge clk_in); #1;
            if (v) beats++;
            if (beats == bl + 1) begin
                wr_j = j + 1;
                wr_done_last = bus.done_out;
                wr_wrap = bus.wrap_out;
            end else if (bus.done_out === 1'b1) wr_early++;
        end
        bus.wvalid_in = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_in = 1'b0;
        bus.req_in = 1'b0; bus.we_in = 1'b0; bus.addr_in = '0; bus.blen_in = '0;
        bus.wvalid_in = 1'b0; bus.wdata_in = '0;
        #3;
        n_cmp++;
        if ({bus.ready_out, bus.rvalid_out, bus.done_out, bus.wrap_out, bus.rdata_out} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b done=%b wrap=%b rdata=%h, want all 0",
                     bus.ready_out, bus.rvalid_out, bus.done_out, bus.wrap_out, bus.rdata_out);
        end
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b1;
        n_cmp++;
        if (bus.ready_out !== 1'b0) begin
            n_err++; $display("FAIL clear_ready_low: got %b want 0", bus.ready_out);
        end
        count_clear(n);
        n_cmp++;
        if (n !== DEPTH) begin
            n_err++; $display("FAIL clear_cycles: got %0d want %0d", n, DEPTH);
        end
        model_clear();
        foreach (wr_dat[i]) wr_dat[i] = '0;
        for (int t = 0; t < 2; t++) begin
            int a;
            a = (t == 0) ? 0 : DEPTH - 16;
            run_read(a, 15, 1'b0);
            n_cmp++;
            if (rd_done_k !== 17 || rd_vmask !== exp_vmask(15) || rd_wrap !== 1'b0) begin
                n_err++;
                $display("FAIL sweep_read_timing a=%h: done_k=%0d vmask=%h wrap=%b, want 17 %h 0",
                         a, rd_done_k, rd_vmask, rd_wrap, exp_vmask(15));
            end
            for (int i = 0; i < rd_data.size(); i++) begin
                n_cmp++;
                if (rd_data[i] !== mem_m[(a + i) % DEPTH]) begin
                    n_err++; $display("FAIL sweep_read_data beat %0d: got %h want %h", i, rd_data[i], mem_m[(a + i) % DEPTH]);
                end
            end
        end
    endtask

    task automatic test_burst();
        wr_dat[0] = 8'hA1; wr_dat[1] = 8'hB2; wr_dat[2] = 8'hC3; wr_dat[3] = 8'hD4;
        run_write('h010, 3, '1);
        n_cmp++;
        if (wr_j !== 4 || wr_done_last !== 1'b1 || wr_early !== 0 || wr_wrap !== 1'b0 || bus.ready_out !== 1'b1) begin
            n_err++;
            $display("FAIL burst_write: j=%0d done=%b early=%0d wrap=%b rdy=%b, want 4 1 0 0 1",
                     wr_j, wr_done_last, wr_early, wr_wrap, bus.ready_out);
        end
        model_write('h010, 3);
        run_read('h010, 3, 1'b0);
        n_cmp++;
        if (rd_done_k !== 5 || rd_vmask !== exp_vmask(3) || rd_wrap !== 1'b0) begin
            n_err++;
            $display("FAIL burst_read_timing: done_k=%0d vmask=%h wrap=%b, want 5 %h 0",
                     rd_done_k, rd_vmask, rd_wrap, exp_vmask(3));
        end
        n_cmp++;
        if (rd_data.size() != 4) begin
            n_err++; $display("FAIL burst_read_count: got %0d want 4", rd_data.size());
        end
        for (int i = 0; i < rd_data.size(); i++) begin
            n_cmp++;
            if (rd_data[i] !== mem_m['h010 + i]) begin
                n_err++; $display("FAIL burst_read_data beat %0d: got %h want %h", i, rd_data[i], mem_m['h010 + i]);
            end
        end
    endtask

    task automatic test_stall();
        int a;
        a = 'h300;
        for (int i = 0; i < 4; i++) wr_dat[i] = DW'(8'h40 + i);
        run_write(a, 3, '1);
        model_write(a, 3);
        wr_dat[0] = 8'h5C; wr_dat[1] = 8'h6D;
        run_write(a, 1, {{60{1'b1}}, 4'b1001});
        n_cmp++;
        if (wr_j !== 4 || wr_done_last !== 1'b1 || wr_early !== 0) begin
            n_err++;
            $display("FAIL stall_write: j=%0d done=%b early=%0d, want 4 1 0", wr_j, wr_done_last, wr_early);
        end
        model_write(a, 1);
        run_read(a, 3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_data.size() <= i || rd_data[i] !== mem_m[a + i]) begin
                n_err++; $display("FAIL stall_read beat %0d: got %h want %h", i,
                                  (rd_data.size() > i) ? rd_data[i] : 8'hxx, mem_m[a + i]);
            end
        end
    endtask

    task automatic test_wrap();
        int a;
        wr_dat[0] = 8'h11; wr_dat[1] = 8'h22; wr_dat[2] = 8'h33;
        run_write(DEPTH - 1, 2, '1);
        n_cmp++;
        if (wr_done_last !== 1'b1 || wr_wrap !== 1'b1) begin
            n_err++; $display("FAIL wrap_write: done=%b wrap=%b want 1 1", wr_done_last, wr_wrap);
        end
        model_write(DEPTH - 1, 2);
        for (int t = 0; t < 3; t++) begin
            int bl;
            a  = (t == 0) ? DEPTH - 1 : (t == 1) ? 0 : DEPTH - 3;
            bl = (t == 1) ? 1 : 2;
            run_read(a, bl, 1'b0);
            n_cmp++;
            if (rd_wrap !== exp_wrap(a, bl) || rd_done_k !== bl + 2) begin
                n_err++; $display("FAIL wrap_read a=%h: wrap=%b done_k=%0d want %b %0d",
                                  a, rd_wrap, rd_done_k, exp_wrap(a, bl), bl + 2);
            end
            for (int i = 0; i < rd_data.size(); i++) begin
                n_cmp++;
                if (rd_data[i] !== mem_m[(a + i) % DEPTH]) begin
                    n_err++; $display("FAIL wrap_data a=%h beat %0d: got %h want %h", a, i, rd_data[i], mem_m[(a + i) % DEPTH]);
                end
            end
        end
        run_write(DEPTH - 3, 2, '1);
        n_cmp++;
        if (wr_done_last !== 1'b1 || wr_wrap !== 1'b0) begin
            n_err++; $display("FAIL nowrap_write: done=%b wrap=%b want 1 0", wr_done_last, wr_wrap);
        end
        model_write(DEPTH - 3, 2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) wr_dat[i] = DW'($urandom_range(1, 255));
        run_write('h420, 5, '1);
        model_write('h420, 5);
        run_read('h420, 5, 1'b1);
        n_cmp++;
        if (rd_wait !== 0 || rd_done_k !== 7 || rd_vmask !== exp_vmask(5)) begin
            n_err++; $display("FAIL b2b_wr_rd: wait=%0d done_k=%0d vmask=%h want 0 7 %h",
                              rd_wait, rd_done_k, rd_vmask, exp_vmask(5));
        end
        for (int i = 0; i < rd_data.size(); i++) begin
            n_cmp++;
            if (rd_data[i] !== mem_m['h420 + i]) begin
                n_err++; $display("FAIL b2b_data beat %0d: got %h want %h", i, rd_data[i], mem_m['h420 + i]);
            end
        end
        run_read('h010, 3, 1'b1);
        n_cmp++;
        if (rd_wait !== 0 || rd_done_k !== 5 || rd_data.size() != 4) begin
            n_err++; $display("FAIL b2b_rd_rd: wait=%0d done_k=%0d n=%0d want 0 5 4", rd_wait, rd_done_k, rd_data.size());
        end
        @(posedge clk_in); #1;
        n_cmp++;
        if (bus.ready_out !== 1'b1 || bus.rvalid_out !== 1'b0 || bus.done_out !== 1'b0) begin
            n_err++; $display("FAIL ignored_req: rdy=%b rv=%b done=%b want 1 0 0",
                              bus.ready_out, bus.rvalid_out, bus.done_out);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int a, bl, ra, rbl;
            logic [63:0] pat;
            a  = $urandom_range(0, DEPTH - 1);
            bl = $urandom_range(0, 15);
            for (int i = 0; i <= bl; i++) wr_dat[i] = DW'($urandom);
            for (int j = 0; j < 64; j++) pat[j] = ($urandom_range(0, 99) < 65);
            run_write(a, bl, pat);
            n_cmp++;
            if (wr_done_last !== 1'b1 || wr_early !== 0 || wr_wrap !== exp_wrap(a, bl)) begin
                n_err++; $display("FAIL rand_write it=%0d a=%h bl=%0d: done=%b early=%0d wrap=%b want 1 0 %b",
                                  it, a, bl, wr_done_last, wr_early, wr_wrap, exp_wrap(a, bl));
            end
            model_write(a, bl);
            ra  = (a + DEPTH - $urandom_range(0, 4)) % DEPTH;
            rbl = $urandom_range(0, 15);
            run_read(ra, rbl, 1'($urandom));
            n_cmp++;
            if (rd_done_k !== rbl + 2 || rd_vmask !== exp_vmask(rbl) || rd_wrap !== exp_wrap(ra, rbl)) begin
                n_err++; $display("FAIL rand_read it=%0d a=%h bl=%0d: done_k=%0d vmask=%h wrap=%b",
                                  it, ra, rbl, rd_done_k, rd_vmask, rd_wrap);
            end
            for (int i = 0; i < rd_data.size(); i++) begin
                n_cmp++;
                if (rd_data[i] !== mem_m[(ra + i) % DEPTH]) begin
                    n_err++; $display("FAIL rand_data it=%0d beat %0d: got %h want %h", it, i, rd_data[i], mem_m[(ra + i) % DEPTH]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int i = 0; i < 4; i++) wr_dat[i] = DW'(8'h90 + i);
        run_write('h100, 3, '1);
        model_write('h100, 3);
        run_read('h100, 3, 1'b0);
        repeat (2) @(posedge clk_in);
        #1;
        n_cmp++;
        if (bus.rdata_out !== mem_m['h103] || bus.rvalid_out !== 1'b0) begin
            n_err++; $display("FAIL rdata_hold: got %h rv=%b want %h 0", bus.rdata_out, bus.rvalid_out, mem_m['h103]);
        end
        bus.req_in = 1'b1; bus.we_in = 1'b1; bus.addr_in = AW'('h200); bus.blen_in = BW'(7);
        @(posedge clk_in); #1;
        bus.req_in = 1'b0;
        bus.wvalid_in = 1'b1; bus.wdata_in = 8'h77;
        @(posedge clk_in); #1;
        bus.wdata_in = 8'h88;
        #2 rst_in = 1'b0;
        #1;
        n_cmp++;
        if ({bus.ready_out, bus.rvalid_out, bus.done_out, bus.wrap_out, bus.rdata_out} !== '0) begin
            n_err++; $display("FAIL midreset_outputs: rdy=%b rv=%b done=%b wrap=%b rdata=%h want all 0",
                              bus.ready_out, bus.rvalid_out, bus.done_out, bus.wrap_out, bus.rdata_out);
        end
        bus.wvalid_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;
        count_clear(n);
        n_cmp++;
        if (n !== DEPTH) begin
            n_err++; $display("FAIL midreset_clear_cycles: got %0d want %0d", n, DEPTH);
        end
        model_clear();
        run_read('h200, 7, 1'b0);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (rd_data.size() <= i || rd_data[i] !== mem_m['h200 + i]) begin
                n_err++; $display("FAIL midreset_wiped beat %0d: got %h want %h", i,
                                  (rd_data.size() > i) ? rd_data[i] : 8'hxx, mem_m['h200 + i]);
            end
        end
        run_read('h100, 3, 1'b0);
        n_cmp++;
        if (rd_data.size() != 4 || rd_data[0] !== mem_m['h100] || rd_data[3] !== mem_m['h103]) begin
            n_err++; $display("FAIL midreset_old_wiped: n=%0d first=%h want 4 00", rd_data.size(),
                              (rd_data.size() > 0) ? rd_data[0] : 8'hxx);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_burst();
        test_stall();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
